// File: rtl/da_pkg.sv
// Shared types and index helpers for the distributed-arithmetic tap serializer.
package da_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int ngrp(input int taps, input int group);
        return taps / group;
    endfunction

    function automatic int nbeat(input int data_w, input int bpc);
        return data_w / bpc;
    endfunction

    // Bit position in a_addr for tap g*group+j, bit-plane p of the current beat.
    function automatic int addr_idx(input int g, input int p, input int j,
                                    input int bpc, input int group);
        return (g * bpc + p) * group + j;
    endfunction

endpackage

// File: rtl/da_shift_word.sv
// One shadow tap word: parallel load, then shifts right BPC bits per enable.
module da_shift_word #(
    parameter int DATA_W = 16,
    parameter int BPC    = 1
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              load,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [BPC-1:0]    plane
);

    logic [DATA_W-1:0] word_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clear) begin
            word_q <= '0;
        end else if (load) begin
            word_q <= din;
        end else if (en) begin
            word_q <= word_q >> BPC;
        end
    end

    assign plane = word_q[BPC-1:0];

endmodule

// File: rtl/da_tap_serializer.sv
// Sample delay line plus beat sequencer that streams tap bit-planes, LSB first,
// as DA LUT address words with valid/ready backpressure.
module da_tap_serializer
    import da_pkg::*;
#(
    parameter int TAPS   = 64,
    parameter int DATA_W = 16,
    parameter int GROUP  = 8,
    parameter int BPC    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_W-1:0]     s_data,
    output logic                  a_valid,
    input  logic                  a_ready,
    output logic [TAPS*BPC-1:0]   a_addr,
    output logic                  a_first,
    output logic                  a_last
);

    localparam int NGRP   = ngrp(TAPS, GROUP);
    localparam int NBEAT  = nbeat(DATA_W, BPC);
    localparam int BEAT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                last_beat;
    logic                accept;
    logic                beat_fire;
    logic                clear;
    logic [DATA_W-1:0]   dly [TAPS];
    logic [DATA_W-1:0]   load_word [TAPS];
    logic [BPC-1:0]      plane [TAPS];

    assign clear     = reset | flush;
    assign last_beat = (beat_q == BEAT_W'(NBEAT - 1));
    assign beat_fire = (state_q == SHIFT) & a_ready;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        s_ready = 1'b0;
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE:    s_ready = 1'b1;
            SHIFT:   s_ready = last_beat & a_ready;
            default: s_ready = 1'b0;
        endcase
        if (clear) begin
            s_ready = 1'b0;
        end
        accept = s_valid & s_ready;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    beat_d  = '0;
                end
            end
            SHIFT: begin
                if (a_ready) begin
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = accept ? SHIFT : IDLE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d = IDLE;
            beat_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // NOTE: the delay line is cleared explicitly because flush must zero the sample history, not just reset.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int k = 0; k < TAPS; k++) dly[k] <= '0;
        end else if (accept) begin
            dly[0] <= s_data;
            for (int k = 1; k < TAPS; k++) dly[k] <= dly[k-1];
        end
    end

    // The shadow loads the post-shift delay line so beat 0 already sees the new sample.
    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        if (k == 0) begin : g_head
            assign load_word[k] = s_data;
        end else begin : g_tail
            assign load_word[k] = dly[k-1];
        end

        da_shift_word #(
            .DATA_W (DATA_W),
            .BPC    (BPC)
        ) u_word (
            .clk   (clk),
            .clear (clear),
            .load  (accept),
            .en    (beat_fire),
            .din   (load_word[k]),
            .plane (plane[k])
        );
    end

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        for (genvar p = 0; p < BPC; p++) begin : g_plane
            for (genvar j = 0; j < GROUP; j++) begin : g_bit
                localparam int IDX = addr_idx(g, p, j, BPC, GROUP);
                assign a_addr[IDX] = plane[g*GROUP+j][p];
            end
        end
    end

    assign a_valid = (state_q == SHIFT);
    assign a_first = a_valid & (beat_q == '0);
    assign a_last  = a_valid & last_beat;

endmodule

// File: tb/tb_da_tap_serializer.sv
// Randomised bench for da_tap_serializer against a sample-history model (BPC=1 and BPC=2).
module tb_da_tap_serializer;

    localparam int T  = 8;
    localparam int G  = 4;
    localparam int DW = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush1, s_valid1, s_ready1, a_valid1, a_ready1, a_first1, a_last1;
    logic [15:0] s_data1;
    logic [7:0]  a_addr1;
    logic        flush2, s_valid2, s_ready2, a_valid2, a_ready2, a_first2, a_last2;
    logic [15:0] s_data2;
    logic [15:0] a_addr2;

    int checks = 0;
    int errors = 0;
    logic [15:0] hist [T];

    always #5 clk = ~clk;

    da_tap_serializer #(.TAPS(T), .DATA_W(DW), .GROUP(G), .BPC(1)) u_dut1 (
        .clk(clk), .reset(reset), .flush(flush1),
        .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1),
        .a_valid(a_valid1), .a_ready(a_ready1), .a_addr(a_addr1),
        .a_first(a_first1), .a_last(a_last1)
    );

    da_tap_serializer #(.TAPS(T), .DATA_W(DW), .GROUP(G), .BPC(2)) u_dut2 (
        .clk(clk), .reset(reset), .flush(flush2),
        .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
        .a_valid(a_valid2), .a_ready(a_ready2), .a_addr(a_addr2),
        .a_first(a_first2), .a_last(a_last2)
    );

    // Address word straight from the definition: bit (g*bpc+p)*G+j = bit (beat*bpc+p) of tap g*G+j.
    function automatic logic [15:0] exp_addr(input int bpc, input int beat);
        logic [15:0] r;
        r = '0;
        for (int g = 0; g < T / G; g++)
            for (int p = 0; p < bpc; p++)
                for (int j = 0; j < G; j++)
                    r[(g*bpc+p)*G+j] = hist[g*G+j][beat*bpc+p];
        return r;
    endfunction

    task automatic push(input logic [15:0] d);
        for (int k = T - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = d;
    endtask

    task automatic clear_hist();
        for (int k = 0; k < T; k++) hist[k] = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush1 = 1'b0; s_valid1 = 1'b0; a_ready1 = 1'b0; s_data1 = '0;
        flush2 = 1'b0; s_valid2 = 1'b0; a_ready2 = 1'b0; s_data2 = '0;
        step();
        step();
        reset = 1'b0;
        clear_hist();
    endtask

    task automatic send1(input logic [15:0] d);
        s_valid1 = 1'b1;
        s_data1  = d;
        #1;
        checks++;
        if (s_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL send_ready got=%b exp=1", s_ready1);
        end
        step();
        s_valid1 = 1'b0;
        s_data1  = 16'($urandom);
        push(d);
    endtask

    // Walks one word on dut1 from start_b to the last beat, with random or fixed stalls.
    task automatic serialize1(input int start_b, input int stall_pct, input int stall_beat);
        int b = start_b;
        int cyc = 0;
        int stalled = 0;
        logic ar;
        logic [15:0] e;
        while (b < DW && cyc < 200) begin
            if (b == stall_beat && stalled < 3) begin
                ar = 1'b0;
                stalled++;
            end else begin
                ar = ($urandom_range(99) >= stall_pct);
            end
            a_ready1 = ar;
            #1;
            e = exp_addr(1, b);
            checks += 5;
            if (a_valid1 !== 1'b1) begin
                errors++; $display("FAIL a_valid beat=%0d got=%b exp=1", b, a_valid1);
            end
            if (a_addr1 !== e[7:0]) begin
                errors++; $display("FAIL a_addr beat=%0d got=%h exp=%h", b, a_addr1, e[7:0]);
            end
            if (a_first1 !== (b == 0)) begin
                errors++; $display("FAIL a_first beat=%0d got=%b exp=%b", b, a_first1, b == 0);
            end
            if (a_last1 !== (b == DW - 1)) begin
                errors++; $display("FAIL a_last beat=%0d got=%b exp=%b", b, a_last1, b == DW - 1);
            end
            if (s_ready1 !== (ar && b == DW - 1)) begin
                errors++; $display("FAIL s_ready_busy beat=%0d got=%b exp=%b", b, s_ready1, ar && b == DW - 1);
            end
            step();
            if (ar) b++;
            cyc++;
        end
        checks++;
        if (cyc >= 200) begin
            errors++; $display("FAIL word_timeout beat=%0d", b);
        end
        a_ready1 = 1'b1;
        #1;
        checks += 2;
        if (a_valid1 !== 1'b0) begin
            errors++; $display("FAIL idle_valid got=%b exp=0", a_valid1);
        end
        if (s_ready1 !== 1'b1) begin
            errors++; $display("FAIL idle_ready got=%b exp=1", s_ready1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush1 = 1'b0; s_valid1 = 1'b1; a_ready1 = 1'b1; s_data1 = 16'hffff;
        flush2 = 1'b0; s_valid2 = 1'b0; a_ready2 = 1'b0; s_data2 = '0;
        step();
        step();
        checks += 5;
        if (s_ready1 !== 1'b0) begin errors++; $display("FAIL rst_s_ready got=%b exp=0", s_ready1); end
        if (a_valid1 !== 1'b0) begin errors++; $display("FAIL rst_a_valid got=%b exp=0", a_valid1); end
        if (a_first1 !== 1'b0) begin errors++; $display("FAIL rst_a_first got=%b exp=0", a_first1); end
        if (a_last1 !== 1'b0)  begin errors++; $display("FAIL rst_a_last got=%b exp=0", a_last1); end
        if (a_addr1 !== 8'h00) begin errors++; $display("FAIL rst_a_addr got=%h exp=00", a_addr1); end
        reset = 1'b0;
        s_valid1 = 1'b0;
        #1;
        checks++;
        if (s_ready1 !== 1'b1) begin errors++; $display("FAIL post_rst_ready got=%b exp=1", s_ready1); end
        clear_hist();
        step();
    endtask

    task automatic test_single();
        do_reset();
        send1(16'h0001);
        serialize1(0, 0, -1);
    endtask

    task automatic test_sign();
        do_reset();
        send1(16'h8000);
        serialize1(0, 0, -1);
    endtask

    task automatic test_delay_line();
        do_reset();
        send1(16'd1);
        serialize1(0, 0, -1);
        send1(16'd2);
        serialize1(0, 0, -1);
        send1(16'd3);
        a_ready1 = 1'b1;
        #1;
        checks++;
        if (a_addr1 !== 8'b0000_0101) begin
            errors++; $display("FAIL dly_beat0 got=%b exp=00000101", a_addr1);
        end
        step();
        checks++;
        if (a_addr1 !== 8'b0000_0011) begin
            errors++; $display("FAIL dly_beat1 got=%b exp=00000011", a_addr1);
        end
        serialize1(1, 0, -1);
    endtask

    task automatic test_backpressure();
        do_reset();
        send1(16'($urandom));
        serialize1(0, 0, 5);
    endtask

    task automatic test_random();
        do_reset();
        for (int w = 0; w < 6; w++) begin
            send1(16'($urandom));
            serialize1(0, 30, -1);
            repeat ($urandom_range(2)) begin
                step();
                checks++;
                if (a_valid1 !== 1'b0) begin
                    errors++; $display("FAIL gap_valid got=%b exp=0", a_valid1);
                end
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        send1(16'($urandom));
        serialize1(0, 0, -1);
        send1(16'($urandom));
        a_ready1 = 1'b1;
        repeat (3) step();
        flush1   = 1'b1;
        s_valid1 = 1'b1;
        s_data1  = 16'($urandom);
        #1;
        checks++;
        if (s_ready1 !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b exp=0", s_ready1); end
        step();
        flush1   = 1'b0;
        s_valid1 = 1'b0;
        clear_hist();
        #1;
        checks += 4;
        if (a_valid1 !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", a_valid1); end
        if (a_first1 !== 1'b0) begin errors++; $display("FAIL flush_first got=%b exp=0", a_first1); end
        if (a_last1 !== 1'b0)  begin errors++; $display("FAIL flush_last got=%b exp=0", a_last1); end
        if (s_ready1 !== 1'b1) begin errors++; $display("FAIL flush_idle_ready got=%b exp=1", s_ready1); end
        send1(16'($urandom) | 16'h0001);
        serialize1(0, 0, -1);
    endtask

    task automatic test_back_to_back();
        localparam int NB = DW / 2;
        localparam int NW = 5;
        logic [15:0] e;
        int b;
        do_reset();
        a_ready2 = 1'b1;
        s_valid2 = 1'b1;
        s_data2  = 16'($urandom);
        #1;
        checks++;
        if (s_ready2 !== 1'b1) begin errors++; $display("FAIL b2b_first_ready got=%b exp=1", s_ready2); end
        step();
        push(s_data2);
        s_data2 = 16'($urandom);
        for (int c = 0; c < NB * NW; c++) begin
            b = c % NB;
            s_valid2 = (c / NB < NW - 1);
            #1;
            e = exp_addr(2, b);
            checks += 5;
            if (a_valid2 !== 1'b1) begin
                errors++; $display("FAIL b2b_valid c=%0d got=%b exp=1", c, a_valid2);
            end
            if (a_addr2 !== e) begin
                errors++; $display("FAIL b2b_addr c=%0d got=%h exp=%h", c, a_addr2, e);
            end
            if (a_first2 !== (b == 0)) begin
                errors++; $display("FAIL b2b_first c=%0d got=%b exp=%b", c, a_first2, b == 0);
            end
            if (a_last2 !== (b == NB - 1)) begin
                errors++; $display("FAIL b2b_last c=%0d got=%b exp=%b", c, a_last2, b == NB - 1);
            end
            if (s_ready2 !== (b == NB - 1)) begin
                errors++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, s_ready2, b == NB - 1);
            end
            step();
            if (b == NB - 1 && s_valid2) begin
                push(s_data2);
                s_data2 = 16'($urandom);
            end
        end
        s_valid2 = 1'b0;
        #1;
        checks += 2;
        if (a_valid2 !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got=%b exp=0", a_valid2); end
        if (s_ready2 !== 1'b1) begin errors++; $display("FAIL b2b_end_ready got=%b exp=1", s_ready2); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sign();
        test_delay_line();
        test_backpressure();
        test_random();
        test_flush();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

endmodule
